// File: rtl/round_sequencer.sv
// Round sequencer: owns level, lives, level timer and post-hit invulnerability for one
// play session, and raises the held win/dead flags consumed by the screen FSM.
module round_sequencer #(
    parameter int unsigned  NUM_LEVELS   = 4,
    parameter int unsigned  LIVES        = 3,
    parameter int unsigned  LEVEL_TICKS  = 1800,
    parameter int unsigned  INVULN_TICKS = 60,
    parameter int unsigned  PAUSE_TICKS  = 90,
    parameter int unsigned  TICK_W       = 11,
    localparam int unsigned LVL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              menu,
    input  logic              start,
    input  logic              tick,
    input  logic              collision,
    input  logic              goal_reached,
    output logic              playing,
    output logic              invuln,
    output logic [LVL_W-1:0]  level,
    output logic [2:0]        lives,
    output logic [TICK_W-1:0] timer,
    output logic              level_up,
    output logic              win,
    output logic              dead
);

    // Elaboration-time parameter sanity checks.
    if (INVULN_TICKS == 0) begin : g_bad_invuln
        $error("round_sequencer: INVULN_TICKS must be nonzero");
    end
    if (PAUSE_TICKS == 0) begin : g_bad_pause
        $error("round_sequencer: PAUSE_TICKS must be nonzero");
    end
    if (LEVEL_TICKS == 0) begin : g_bad_level_ticks
        $error("round_sequencer: LEVEL_TICKS must be nonzero");
    end
    if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
        $error("round_sequencer: LIVES must be in 1..7");
    end
    if (NUM_LEVELS < 1) begin : g_bad_levels
        $error("round_sequencer: NUM_LEVELS must be at least 1");
    end
    if (LEVEL_TICKS >= (1 << TICK_W) || INVULN_TICKS >= (1 << TICK_W) ||
        PAUSE_TICKS >= (1 << TICK_W)) begin : g_bad_tick_w
        $error("round_sequencer: TICK_W too narrow for the tick counts");
    end

    localparam logic [TICK_W-1:0] LevelTicks  = TICK_W'(LEVEL_TICKS);
    localparam logic [TICK_W-1:0] InvulnTicks = TICK_W'(INVULN_TICKS);
    localparam logic [TICK_W-1:0] PauseTicks  = TICK_W'(PAUSE_TICKS);
    localparam logic [TICK_W-1:0] TickOne     = TICK_W'(1);
    localparam logic [2:0]        LivesInit   = 3'(LIVES);
    localparam logic [LVL_W-1:0]  LastLevel   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0]  LevelOne    = LVL_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StRespawn,
        StLevelUp,
        StDoneWin,
        StDoneDead
    } state_e;

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [2:0]        lives_q, lives_d;
    logic [TICK_W-1:0] timer_q, timer_d;
    logic [TICK_W-1:0] inv_q, inv_d;
    logic [TICK_W-1:0] pause_q, pause_d;
    logic              level_up_q, level_up_d;
    logic              playing_q, invuln_q, win_q, dead_q;
    logic              lose_life;

    // Next-state and counter update; menu/idle handling takes precedence over the play states.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        inv_d      = inv_q;
        pause_d    = pause_q;
        level_up_d = 1'b0;
        // Timeout costs a life exactly like a hit.
        lose_life  = collision | (tick & (timer_q == TickOne));

        if (menu || state_q == StIdle) begin
            if (start) begin
                level_d = '0;
                lives_d = LivesInit;
                timer_d = LevelTicks;
                state_d = StPlay;
            end else if (menu) begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (lose_life) begin
                        if (lives_q <= 3'd1) begin
                            lives_d = '0;
                            state_d = StDoneDead;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            timer_d = LevelTicks;
                            inv_d   = InvulnTicks;
                            state_d = StRespawn;
                        end
                    end else if (goal_reached) begin
                        if (level_q == LastLevel) begin
                            state_d = StDoneWin;
                        end else begin
                            pause_d    = PauseTicks;
                            level_up_d = 1'b1;
                            state_d    = StLevelUp;
                        end
                    end else if (tick && timer_q != '0) begin
                        timer_d = timer_q - TickOne;
                    end
                end

                StRespawn: begin
                    if (tick) begin
                        if (inv_q <= TickOne) begin
                            inv_d   = '0;
                            state_d = StPlay;
                        end else begin
                            inv_d = inv_q - TickOne;
                        end
                    end
                end

                StLevelUp: begin
                    if (tick) begin
                        if (pause_q <= TickOne) begin
                            pause_d = '0;
                            level_d = level_q + LevelOne;
                            timer_d = LevelTicks;
                            state_d = StPlay;
                        end else begin
                            pause_d = pause_q - TickOne;
                        end
                    end
                end

                // Idle is handled above; the done states hold everything until menu.
                default: begin
                end
            endcase
        end
    end

    // State, counters and registered decoded outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            level_q    <= '0;
            lives_q    <= '0;
            timer_q    <= '0;
            inv_q      <= '0;
            pause_q    <= '0;
            level_up_q <= 1'b0;
            playing_q  <= 1'b0;
            invuln_q   <= 1'b0;
            win_q      <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            lives_q    <= lives_d;
            timer_q    <= timer_d;
            inv_q      <= inv_d;
            pause_q    <= pause_d;
            level_up_q <= level_up_d;
            playing_q  <= (state_d == StPlay);
            invuln_q   <= (state_d == StRespawn);
            win_q      <= (state_d == StDoneWin);
            dead_q     <= (state_d == StDoneDead);
        end
    end

    assign playing  = playing_q;
    assign invuln   = invuln_q;
    assign level    = level_q;
    assign lives    = lives_q;
    assign timer    = timer_q;
    assign level_up = level_up_q;
    assign win      = win_q;
    assign dead     = dead_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a behavioural session model.
module tb_round_sequencer;

    localparam int NL = 4;
    localparam int LV = 3;
    localparam int LT = 1800;
    localparam int IT = 60;
    localparam int PT = 90;
    localparam int TW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          menu = 1'b0, start = 1'b0, tick = 1'b0;
    logic          collision = 1'b0, goal_reached = 1'b0;
    logic          playing, invuln, level_up, win, dead;
    logic [1:0]    level;
    logic [2:0]    lives;
    logic [TW-1:0] timer;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    round_sequencer #(
        .NUM_LEVELS  (NL),
        .LIVES       (LV),
        .LEVEL_TICKS (LT),
        .INVULN_TICKS(IT),
        .PAUSE_TICKS (PT),
        .TICK_W      (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .menu        (menu),
        .start       (start),
        .tick        (tick),
        .collision   (collision),
        .goal_reached(goal_reached),
        .playing     (playing),
        .invuln      (invuln),
        .level       (level),
        .lives       (lives),
        .timer       (timer),
        .level_up    (level_up),
        .win         (win),
        .dead        (dead)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural session model: phase of play plus plain integer counters.
    localparam int M_IDLE = 0, M_PLAY = 1, M_RESPAWN = 2, M_PAUSE = 3, M_WON = 4, M_LOST = 5;
    int m_phase = M_IDLE;
    int m_level = 0, m_lives = 0, m_timer = 0, m_inv = 0, m_pause = 0;
    bit m_lu = 1'b0;

    task automatic m_new_game();
        m_level = 0;
        m_lives = LV;
        m_timer = LT;
        m_phase = M_PLAY;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = M_IDLE;
            m_level = 0; m_lives = 0; m_timer = 0; m_inv = 0; m_pause = 0;
            m_lu = 1'b0;
        end else begin
            m_lu = 1'b0;
            if (menu && start) m_new_game();
            else if (menu) m_phase = M_IDLE;
            else if (m_phase == M_IDLE) begin
                if (start) m_new_game();
            end else if (m_phase == M_PLAY) begin
                if (collision || (tick && m_timer == 1)) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_phase = M_LOST;
                    else begin
                        m_timer = LT;
                        m_inv = IT;
                        m_phase = M_RESPAWN;
                    end
                end else if (goal_reached) begin
                    if (m_level == NL - 1) m_phase = M_WON;
                    else begin
                        m_pause = PT;
                        m_lu = 1'b1;
                        m_phase = M_PAUSE;
                    end
                end else if (tick && m_timer > 0) m_timer = m_timer - 1;
            end else if (m_phase == M_RESPAWN) begin
                if (tick) begin
                    m_inv = m_inv - 1;
                    if (m_inv == 0) m_phase = M_PLAY;
                end
            end else if (m_phase == M_PAUSE) begin
                if (tick) begin
                    m_pause = m_pause - 1;
                    if (m_pause == 0) begin
                        m_level = m_level + 1;
                        m_timer = LT;
                        m_phase = M_PLAY;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset && armed) begin
            chk("playing", playing, m_phase == M_PLAY);
            chk("invuln", invuln, m_phase == M_RESPAWN);
            chk("win", win, m_phase == M_WON);
            chk("dead", dead, m_phase == M_LOST);
            chk("level_up", level_up, m_lu);
            chk("level", level, m_level);
            chk("lives", lives, m_lives);
            chk("timer", timer, m_timer);
        end
    end

    task automatic step(input bit mn, input bit st, input bit tk, input bit co, input bit go);
        @(negedge clk);
        menu = mn; start = st; tick = tk; collision = co; goal_reached = go;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 0, 1, 0, 0);
    endtask

    task automatic advance_level();
        step(0, 0, 0, 0, 1);
        ticks(PT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        armed = 1'b1;
        #1;
        chk("reset_playing", playing, 0);
        chk("reset_lives", lives, 0);
        chk("reset_timer", timer, 0);

        // Start and countdown.
        step(1, 1, 0, 0, 0);
        chk("start_playing", playing, 1);
        chk("start_level", level, 0);
        chk("start_lives", lives, 3);
        chk("start_timer", timer, 1800);
        ticks(5);
        chk("tick5_timer", timer, 1795);

        // Asynchronous reset mid-play.
        @(negedge clk);
        menu = 0; start = 0; tick = 0; collision = 0; goal_reached = 0;
        #2 reset = 1'b0;
        #1;
        chk("async_playing", playing, 0);
        chk("async_lives", lives, 0);
        chk("async_timer", timer, 0);
        @(negedge clk) reset = 1'b1;
        step(0, 0, 1, 0, 0);
        chk("idle_after_rst", playing, 0);

        // Collision, ignored hits while invulnerable, return to play.
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("hit_lives", lives, 2);
        chk("hit_invuln", invuln, 1);
        chk("hit_timer", timer, 1800);
        for (int i = 0; i < IT - 1; i++) step(0, 0, 1, (i % 3) == 0, (i % 5) == 0);
        chk("resp59_invuln", invuln, 1);
        chk("resp59_lives", lives, 2);
        step(0, 0, 1, 1, 0);
        chk("resp60_playing", playing, 1);
        chk("resp60_lives", lives, 2);

        // Final death and menu clear.
        step(0, 0, 0, 1, 0);
        ticks(IT);
        step(0, 0, 0, 1, 0);
        chk("death_dead", dead, 1);
        chk("death_lives", lives, 0);
        ticks(3);
        chk("death_held", dead, 1);
        step(1, 0, 0, 0, 0);
        chk("menu_dead", dead, 0);
        chk("menu_playing", playing, 0);

        // Win path.
        step(1, 1, 0, 0, 0);
        for (int lv = 0; lv < NL - 1; lv++) begin
            step(0, 0, 0, 0, 1);
            chk("lu_pulse", level_up, 1);
            chk("lu_level", level, lv);
            step(0, 0, 0, 0, 0);
            chk("lu_pulse_end", level_up, 0);
            ticks(PT - 1);
            chk("pause_frozen", playing, 0);
            ticks(1);
            chk("pause_done", playing, 1);
            chk("next_level", level, lv + 1);
            chk("next_timer", timer, 1800);
        end
        step(0, 0, 0, 0, 1);
        chk("win_flag", win, 1);
        chk("win_level", level, 3);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 1);
        chk("win_held", win, 1);
        step(1, 0, 0, 0, 0);
        chk("win_clear", win, 0);

        // Collision and goal together at last level with one life.
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        ticks(IT);
        step(0, 0, 0, 1, 0);
        ticks(IT);
        repeat (NL - 1) advance_level();
        chk("tie_lives", lives, 1);
        step(0, 0, 0, 1, 1);
        chk("tie_dead", dead, 1);
        chk("tie_win", win, 0);

        // Timer expiry with two lives.
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        ticks(IT);
        ticks(LT - 1);
        chk("to_timer1", timer, 1);
        chk("to_lives2", lives, 2);
        step(0, 0, 1, 0, 0);
        chk("to_lives", lives, 1);
        chk("to_invuln", invuln, 1);
        chk("to_timer", timer, 1800);

        // Random phase.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            menu = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 9) == 0);
            tick = ($urandom_range(0, 3) != 0);
            collision = ($urandom_range(0, 299) == 0);
            goal_reached = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 4999) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
